// File: rtl/add_sub_seq_ctrl.sv
// Operand/operation sequencer for the 4-bit add/sub calculator demo.
// Buttons are synchronised and edge-detected; results latch after one exec cycle.
module add_sub_seq_ctrl #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_enter,
   input  logic             btn_clr,
   input  logic [WIDTH-1:0] sw_val,
   input  logic             sw_op,
   output logic             alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   input  logic             alu_carry,
   output logic [WIDTH-1:0] res_q,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             carry_q,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_EXEC = 2'd2,
      S_SHOW = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic [SYNC_STAGES-1:0] enter_sync;
   logic [SYNC_STAGES-1:0] clr_sync;
   logic                   enter_hist;
   logic                   clr_hist;
   logic                   enter_evt;
   logic                   clr_evt;

   logic load_a;
   logic load_b;
   logic load_chain;
   logic capture;
   logic clear;

   // Button synchronisers plus one history flop each for rising-edge detect
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enter_sync <= '0;
         clr_sync   <= '0;
         enter_hist <= 1'b0;
         clr_hist   <= 1'b0;
      end else begin
         enter_sync <= {enter_sync[SYNC_STAGES-2:0], btn_enter};
         clr_sync   <= {clr_sync[SYNC_STAGES-2:0], btn_clr};
         enter_hist <= enter_sync[SYNC_STAGES-1];
         clr_hist   <= clr_sync[SYNC_STAGES-1];
      end
   end

   assign enter_evt = enter_sync[SYNC_STAGES-1] & ~enter_hist;
   assign clr_evt   = clr_sync[SYNC_STAGES-1] & ~clr_hist;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_A;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and datapath strobes; clear beats enter and aborts exec
   always_comb begin
      state_nx   = state;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_chain = 1'b0;
      capture    = 1'b0;
      clear      = 1'b0;
      if (clr_evt) begin
         clear    = 1'b1;
         state_nx = S_A;
      end else begin
         case (state)
            S_A: begin
               if (enter_evt) begin
                  load_a   = 1'b1;
                  state_nx = S_B;
               end
            end
            S_B: begin
               if (enter_evt) begin
                  load_b   = 1'b1;
                  state_nx = S_EXEC;
               end
            end
            S_EXEC: begin
               capture  = 1'b1;
               state_nx = S_SHOW;
            end
            S_SHOW: begin
               if (enter_evt) begin
                  load_chain = 1'b1;
                  state_nx   = S_EXEC;
               end
            end
            default: state_nx = S_A;
         endcase
      end
   end

   // Operand registers and latched result/flags
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= 1'b0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         if (load_a) begin
            alu_a <= sw_val;
         end
         if (load_b) begin
            alu_b  <= sw_val;
            alu_op <= sw_op;
         end
         if (load_chain) begin
            alu_a  <= res_q;
            alu_b  <= sw_val;
            alu_op <= sw_op;
         end
         if (capture) begin
            res_q      <= alu_result;
            ovf_q      <= alu_overflow;
            zero_q     <= alu_zero;
            carry_q    <= alu_carry;
            ovf_sticky <= ovf_sticky | alu_overflow;
         end
      end
   end

   // Completed-op counter; survives CLEAR, saturates at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (capture && (op_count != '1)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// Directed testbench for add_sub_seq_ctrl.
// A small behavioural add/sub unit closes the loop on the alu_* ports.
module tb_add_sub_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       btn_enter;
   logic       btn_clr;
   logic [3:0] sw_val;
   logic       sw_op;
   logic       alu_op;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_result;
   logic       alu_overflow;
   logic       alu_zero;
   logic       alu_carry;
   logic [3:0] res_q;
   logic       ovf_q;
   logic       zero_q;
   logic       carry_q;
   logic       ovf_sticky;
   logic [7:0] op_count;
   logic [1:0] state_o;

   int n_chk;
   int n_fail;

   logic [3:0] bm;
   logic [4:0] sum;

   add_sub_seq_ctrl #(
      .WIDTH(4),
      .SYNC_STAGES(2),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_enter(btn_enter),
      .btn_clr(btn_clr),
      .sw_val(sw_val),
      .sw_op(sw_op),
      .alu_op(alu_op),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_result(alu_result),
      .alu_overflow(alu_overflow),
      .alu_zero(alu_zero),
      .alu_carry(alu_carry),
      .res_q(res_q),
      .ovf_q(ovf_q),
      .zero_q(zero_q),
      .carry_q(carry_q),
      .ovf_sticky(ovf_sticky),
      .op_count(op_count),
      .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Add/sub unit: sub = a + ~b + 1, signed overflow, carry-out
   always_comb begin
      bm           = alu_op ? ~alu_b : alu_b;
      sum          = {1'b0, alu_a} + {1'b0, bm} + {4'b0, alu_op};
      alu_result   = sum[3:0];
      alu_carry    = sum[4];
      alu_zero     = (sum[3:0] == 4'h0);
      alu_overflow = (alu_a[3] == bm[3]) && (sum[3] != alu_a[3]);
   end

   task automatic press_enter(input logic [3:0] v, input logic op);
      @(negedge clk);
      sw_val    = v;
      sw_op     = op;
      btn_enter = 1'b1;
      repeat (4) @(negedge clk);
      btn_enter = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic press_clr();
      @(negedge clk);
      btn_clr = 1'b1;
      repeat (4) @(negedge clk);
      btn_clr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      btn_enter = 1'b0;
      btn_clr   = 1'b0;
      sw_val    = 4'h0;
      sw_op     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state got %0d want 0", state_o);
      end
      n_chk++;
      if ({alu_a, alu_b, alu_op, res_q} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_regs got a=%h b=%h op=%b r=%h want 0",
                  alu_a, alu_b, alu_op, res_q);
      end
      n_chk++;
      if ({ovf_q, zero_q, carry_q, ovf_sticky, op_count} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset_flags got %b%b%b%b cnt=%0d want 0",
                  ovf_q, zero_q, carry_q, ovf_sticky, op_count);
      end
   endtask

   task automatic test_add_overflow();
      press_enter(4'd5, 1'b0);
      press_enter(4'd3, 1'b0);
      n_chk++;
      if (state_o !== 2'd3) begin
         n_fail++;
         $display("FAIL add_state got %0d want 3", state_o);
      end
      n_chk++;
      if (res_q !== 4'd8) begin
         n_fail++;
         $display("FAIL add_res got %h want 8", res_q);
      end
      n_chk++;
      if ({ovf_q, carry_q, zero_q} !== 3'b100) begin
         n_fail++;
         $display("FAIL add_flags got ovf=%b c=%b z=%b want 1 0 0",
                  ovf_q, carry_q, zero_q);
      end
      n_chk++;
      if (ovf_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL add_sticky got %b want 1", ovf_sticky);
      end
      n_chk++;
      if (op_count !== 8'd1) begin
         n_fail++;
         $display("FAIL add_count got %0d want 1", op_count);
      end
   endtask

   task automatic test_sub_clear();
      press_clr();
      n_chk++;
      if ({state_o, res_q, ovf_sticky, alu_a} !== 11'h0) begin
         n_fail++;
         $display("FAIL clr_state got st=%0d r=%h s=%b a=%h want 0",
                  state_o, res_q, ovf_sticky, alu_a);
      end
      n_chk++;
      if (op_count !== 8'd1) begin
         n_fail++;
         $display("FAIL clr_count got %0d want 1", op_count);
      end
      press_enter(4'd5, 1'b0);
      press_enter(4'd3, 1'b1);
      n_chk++;
      if (res_q !== 4'd2) begin
         n_fail++;
         $display("FAIL sub_res got %h want 2", res_q);
      end
      n_chk++;
      if ({carry_q, ovf_q, ovf_sticky} !== 3'b100) begin
         n_fail++;
         $display("FAIL sub_flags got c=%b o=%b s=%b want 1 0 0",
                  carry_q, ovf_q, ovf_sticky);
      end
      n_chk++;
      if (op_count !== 8'd2) begin
         n_fail++;
         $display("FAIL sub_count got %0d want 2", op_count);
      end
   endtask

   task automatic test_zero_chain();
      press_clr();
      press_enter(4'd3, 1'b0);
      press_enter(4'd3, 1'b1);
      n_chk++;
      if ({res_q, zero_q, carry_q} !== 6'b0000_11) begin
         n_fail++;
         $display("FAIL zero_res got r=%h z=%b c=%b want 0 1 1",
                  res_q, zero_q, carry_q);
      end
      press_enter(4'd2, 1'b1);
      n_chk++;
      if ({alu_a, alu_b, alu_op} !== 9'b0000_0010_1) begin
         n_fail++;
         $display("FAIL chain_ops got a=%h b=%h op=%b want 0 2 1",
                  alu_a, alu_b, alu_op);
      end
      n_chk++;
      if ({res_q, carry_q, zero_q} !== 6'b1110_00) begin
         n_fail++;
         $display("FAIL chain_res got r=%h c=%b z=%b want e 0 0",
                  res_q, carry_q, zero_q);
      end
      n_chk++;
      if (op_count !== 8'd4) begin
         n_fail++;
         $display("FAIL chain_count got %0d want 4", op_count);
      end
   endtask

   task automatic test_signed_ovf_sticky();
      press_clr();
      press_enter(4'd8, 1'b0);
      press_enter(4'd1, 1'b1);
      n_chk++;
      if ({res_q, ovf_q, carry_q} !== 6'b0111_11) begin
         n_fail++;
         $display("FAIL sovf_res got r=%h o=%b c=%b want 7 1 1",
                  res_q, ovf_q, carry_q);
      end
      press_enter(4'd1, 1'b0);
      n_chk++;
      if ({res_q, ovf_q, carry_q, ovf_sticky} !== 7'b1000_101) begin
         n_fail++;
         $display("FAIL sovf_chain got r=%h o=%b c=%b s=%b want 8 1 0 1",
                  res_q, ovf_q, carry_q, ovf_sticky);
      end
      press_clr();
      n_chk++;
      if (ovf_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL sovf_clear got %b want 0", ovf_sticky);
      end
      n_chk++;
      if (op_count !== 8'd6) begin
         n_fail++;
         $display("FAIL sovf_count got %0d want 6", op_count);
      end
   endtask

   task automatic test_button_events();
      @(negedge clk);
      sw_val    = 4'd9;
      btn_enter = 1'b1;
      repeat (20) @(negedge clk);
      n_chk++;
      if (state_o !== 2'd1) begin
         n_fail++;
         $display("FAIL hold_state got %0d want 1", state_o);
      end
      btn_enter = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if ({state_o, alu_a} !== 6'b01_1001) begin
         n_fail++;
         $display("FAIL hold_after got st=%0d a=%h want 1 9",
                  state_o, alu_a);
      end
      sw_val    = 4'd7;
      btn_enter = 1'b1;
      btn_clr   = 1'b1;
      repeat (4) @(negedge clk);
      btn_enter = 1'b0;
      btn_clr   = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if ({state_o, alu_b, alu_a} !== 10'h0) begin
         n_fail++;
         $display("FAIL both_btn got st=%0d b=%h a=%h want 0 0 0",
                  state_o, alu_b, alu_a);
      end
   endtask

   task automatic test_reset_mid_exec();
      bit seen;
      seen = 1'b0;
      press_enter(4'd4, 1'b0);
      @(negedge clk);
      sw_val    = 4'd2;
      btn_enter = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!seen && state_o == 2'd2) begin
            seen = 1'b1;
            n_chk++;
            if (op_count !== 8'd6) begin
               n_fail++;
               $display("FAIL exec_precount got %0d want 6", op_count);
            end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n     = 1'b1;
            btn_enter = 1'b0;
         end else if (!seen) begin
            @(negedge clk);
         end
      end
      btn_enter = 1'b0;
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL exec_timeout got no S_EXEC want S_EXEC");
      end
      n_chk++;
      if ({state_o, alu_a, alu_b, res_q, op_count} !== 22'h0) begin
         n_fail++;
         $display("FAIL rst_exec got st=%0d a=%h b=%h r=%h c=%0d want 0",
                  state_o, alu_a, alu_b, res_q, op_count);
      end
      repeat (4) @(negedge clk);
      n_chk++;
      if (state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL rst_exec_idle got %0d want 0", state_o);
      end
   endtask

   task automatic test_saturation();
      press_enter(4'd1, 1'b0);
      press_enter(4'd1, 1'b0);
      for (int i = 0; i < 254; i++) begin
         press_enter(4'd1, 1'b0);
      end
      n_chk++;
      if (op_count !== 8'hFF) begin
         n_fail++;
         $display("FAIL sat_reach got %0d want 255", op_count);
      end
      for (int i = 0; i < 255; i++) begin
         press_enter(4'd1, 1'b0);
      end
      n_chk++;
      if (op_count !== 8'hFF) begin
         n_fail++;
         $display("FAIL sat_hold got %0d want 255", op_count);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_add_overflow();
      test_sub_clear();
      test_zero_chain();
      test_signed_ovf_sticky();
      test_button_events();
      test_reset_mid_exec();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
